teknofest_prog_loader: RTL and testbench



---
 rtl/teknofest_prog_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_teknofest_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/teknofest_prog_loader.sv
// UART boot loader: receives a MAGIC-framed program image on prog_rx_i and
// writes it word by word into program RAM, holding the SoC in reset while
// loading and for RST_HOLD_CYCLES afterwards. Bytes are 8N1, LSB first.
module teknofest_prog_loader #(
  parameter int          CLKS_PER_BIT    = 868,
  parameter int          RAM_DEPTH       = 131072,
  parameter int          TIMEOUT_CYCLES  = 10000000,
  parameter int          RST_HOLD_CYCLES = 64,
  parameter logic [31:0] MAGIC           = 32'hA55AC33C
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         prog_rx_i,
  output logic                         ram_we_o,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
  output logic [31:0]                  ram_wdata_o,
  output logic                         system_reset_o,
  output logic                         prog_mode_led_o,
  output logic                         err_o
);

  localparam int AW   = $clog2(RAM_DEPTH);
  localparam int CW   = AW + 1;  // one extra bit so N = RAM_DEPTH does not wrap
  localparam int CNW  = $clog2(CLKS_PER_BIT + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW   = $clog2(RST_HOLD_CYCLES + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_RELEASE} state_t;

  // ---------------- UART receiver ----------------
  logic            sync1, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_state_n;
  logic [CNW-1:0]  rx_cnt, rx_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      rx_byte, rx_byte_n;
  logic            byte_vld, frame_err, start_det;

  // two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= prog_rx_i;
      rx_sync <= sync1;
      rx_prev <= rx_sync;
    end
  end

  // receiver state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      bit_idx  <= bit_idx_n;
      rx_byte  <= rx_byte_n;
    end
  end

  // receiver next state: mid-bit sampling, glitch rejection, stop-bit check
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    bit_idx_n  = bit_idx;
    rx_byte_n  = rx_byte;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    start_det  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          start_det  = 1'b1;
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == CNW'(HALF - 1)) begin
          rx_cnt_n   = '0;
          bit_idx_n  = '0;
          // line back high at mid start bit: treat as a glitch
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n  = '0;
          rx_byte_n = {rx_sync, rx_byte[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_sync) byte_vld  = 1'b1;
          else         frame_err = 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- frame parser ----------------
  state_t          state, state_n;
  logic [31:0]     shreg, word;
  logic [1:0]      byte_cnt;
  logic [CW-1:0]   word_cnt, n_words;
  logic [TW-1:0]   idle_cnt;
  logic [HW-1:0]   hold_cnt;

  logic [31:0]     shreg_next, word_next;
  logic            last_byte, last_word, len_big, timeout, hold_done;

  assign shreg_next = {shreg[23:0], rx_byte};
  assign word_next  = {rx_byte, word[31:8]};   // little-endian packing
  assign last_byte  = byte_vld && (byte_cnt == 2'd3);
  assign last_word  = (word_cnt + CW'(1)) == n_words;
  assign len_big    = word_next > 32'(RAM_DEPTH);
  assign timeout    = (state == S_LEN || state == S_DATA) && !start_det &&
                      (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign hold_done  = hold_cnt == HW'(RST_HOLD_CYCLES - 1);

  // parser state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  // parser next state
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (byte_vld && shreg_next == MAGIC) state_n = S_LEN;
      S_LEN:
        if (timeout) state_n = S_RELEASE;
        else if (last_byte) state_n = (word_next == 32'd0 || len_big) ? S_RELEASE : S_DATA;
      S_DATA:
        if (timeout || (last_byte && last_word)) state_n = S_RELEASE;
      S_RELEASE:
        if (hold_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // parser datapath and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg           <= '0;
      word            <= '0;
      byte_cnt        <= '0;
      word_cnt        <= '0;
      n_words         <= '0;
      idle_cnt        <= '0;
      hold_cnt        <= '0;
      ram_we_o        <= 1'b0;
      ram_addr_o      <= '0;
      ram_wdata_o     <= '0;
      system_reset_o  <= 1'b1;
      prog_mode_led_o <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      ram_we_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (byte_vld) begin
            shreg <= shreg_next;
            if (shreg_next == MAGIC) begin
              err_o           <= 1'b0;
              prog_mode_led_o <= 1'b1;
              system_reset_o  <= 1'b0;
              word_cnt        <= '0;
              byte_cnt        <= '0;
              idle_cnt        <= '0;
            end
          end
        end
        S_LEN, S_DATA: begin
          idle_cnt <= start_det ? '0 : idle_cnt + 1'b1;
          if (timeout || frame_err) begin
            err_o <= 1'b1;
          end else if (byte_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            word     <= word_next;
            if (byte_cnt == 2'd3) begin
              if (state == S_LEN) begin
                n_words <= word_next[CW-1:0];
                if (len_big) err_o <= 1'b1;
              end else begin
                ram_we_o    <= 1'b1;
                ram_addr_o  <= word_cnt[AW-1:0];
                ram_wdata_o <= word_next;
                word_cnt    <= word_cnt + CW'(1);
              end
            end
          end
        end
        S_RELEASE: begin
          prog_mode_led_o <= 1'b0;
          // cleared so stale bytes cannot complete a MAGIC match later
          shreg           <= '0;
          if (hold_done) begin
            hold_cnt       <= '0;
            system_reset_o <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_teknofest_prog_loader.sv
// Self-checking bench for teknofest_prog_loader: UART frames driven bit by bit,
// expected RAM writes queued at stimulus time and compared by a write monitor.
module tb_teknofest_prog_loader;

  localparam int CPB   = 8;
  localparam int DEPTH = 131072;
  localparam int TMO   = 200;
  localparam int HOLD  = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          sys_rst, led, err;

  int checks = 0;
  int errors = 0;

  int   cyc = 0, wr_count = 0, last_wr_cyc = 0;
  int   rst_fall_cyc = 0, rst_rise_cyc = 0;
  logic last_wr_led = 1'b0;
  logic sys_rst_q = 1'b1;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [AW-1:0] ea;
  logic [31:0]   ed;

  teknofest_prog_loader #(
    .CLKS_PER_BIT(CPB), .RAM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO),
    .RST_HOLD_CYCLES(HOLD), .MAGIC(32'hA55AC33C)
  ) dut (
    .clk_i(clk), .rst_i(rst), .prog_rx_i(rx),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .system_reset_o(sys_rst), .prog_mode_led_o(led), .err_o(err)
  );

  always #5 clk = ~clk;

  // write monitor / scoreboard, plus reset-edge timestamps
  always @(negedge clk) begin
    cyc++;
    if (sys_rst_q && !sys_rst) rst_fall_cyc = cyc;
    if (!sys_rst_q && sys_rst) rst_rise_cyc = cyc;
    sys_rst_q = sys_rst;
    if (ram_we === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      last_wr_led = led;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", ram_addr, ram_wdata);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (ram_addr !== ea || ram_wdata !== ed) begin
          errors++;
          $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                   ram_addr, ram_wdata, ea, ed);
        end
      end
    end
  end

  // stimulus helpers
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_magic();
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hC3); send_byte(8'h3C);
  endtask

  task automatic send_le32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_rst_high(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sys_rst === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
    checks++; if (ram_addr !== '0)    begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
    checks++; if (ram_wdata !== '0)   begin errors++; $display("FAIL reset_wdata: got %h expected 0", ram_wdata); end
    checks++; if (sys_rst !== 1'b1)   begin errors++; $display("FAIL reset_sysrst: got %b expected 1", sys_rst); end
    checks++; if (led !== 1'b0)       begin errors++; $display("FAIL reset_led: got %b expected 0", led); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int w0 = wr_count;
    bit ok;
    send_magic();
    checks++; if (led !== 1'b1)     begin errors++; $display("FAIL basic_led_on: got %b expected 1", led); end
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL basic_sysrst_low: got %b expected 0", sys_rst); end
    send_le32(32'd2);
    expect_write(0, 32'h44332211);
    expect_write(1, 32'h88776655);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 17));
    wait_rst_high(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_release: system_reset_o still %b, expected 1", sys_rst); end
    checks++; if (rst_rise_cyc - last_wr_cyc !== HOLD)
      begin errors++; $display("FAIL basic_hold: got %0d cycles expected %0d", rst_rise_cyc - last_wr_cyc, HOLD); end
    checks++; if (last_wr_led !== 1'b1) begin errors++; $display("FAIL basic_led_at_write: got %b expected 1", last_wr_led); end
    checks++; if (led !== 1'b0)     begin errors++; $display("FAIL basic_led_off: got %b expected 0", led); end
    checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL basic_writes: got %0d expected 2", wr_count - w0); end
    checks++; if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL basic_missing: %0d writes missing, expected 0", exp_addr_q.size()); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_noise_len0();
    int w0 = wr_count;
    int f0 = rst_fall_cyc;
    bit ok;
    send_byte(8'h00);
    send_magic();
    send_le32(32'd0);
    wait_rst_high(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_release: system_reset_o still %b, expected 1", sys_rst); end
    checks++; if (rst_fall_cyc == f0) begin errors++; $display("FAIL len0_pulse: no reset pulse seen, expected one"); end
    checks++; if (rst_rise_cyc - rst_fall_cyc < HOLD)
      begin errors++; $display("FAIL len0_width: got %0d cycles expected >= %0d", rst_rise_cyc - rst_fall_cyc, HOLD); end
    checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL len0_writes: got %0d expected 0", wr_count - w0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL len0_err: got %b expected 0", err); end
  endtask

  task automatic test_len_overflow();
    int w0 = wr_count;
    bit ok;
    send_magic();
    send_le32(32'(DEPTH + 1));
    wait_rst_high(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_release: system_reset_o still %b, expected 1", sys_rst); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err); end
    checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL ovf_writes: got %0d expected 0", wr_count - w0); end
    send_magic();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_clear: got %b expected 0", err); end
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL ovf_led_on: got %b expected 1", led); end
    send_le32(32'd0);
    wait_rst_high(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_release2: system_reset_o still %b, expected 1", sys_rst); end
  endtask

  task automatic test_timeout();
    int w0 = wr_count;
    bit ok;
    send_magic();
    send_le32(32'd3);
    expect_write(0, 32'hDDCCBBAA);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE); send_byte(8'hFF);
    wait_rst_high(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_release: system_reset_o still %b, expected 1", sys_rst); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL tmo_writes: got %0d expected 1", wr_count - w0); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
    checks++; if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL tmo_missing: %0d writes missing, expected 0", exp_addr_q.size()); end
  endtask

  task automatic test_framing_glitch();
    int w0 = wr_count;
    bit ok;
    send_magic();
    send_le32(32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL frm_err: got %b expected 1", err); end
    wait_rst_high(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frm_release: system_reset_o still %b, expected 1", sys_rst); end
    checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL frm_writes: got %0d expected 0", wr_count - w0); end
    // short low pulse on an idle line
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL glitch_writes: got %0d expected 0", wr_count - w0); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL glitch_sysrst: got %b expected 1", sys_rst); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL glitch_led: got %b expected 0", led); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL glitch_err: got %b expected 1", err); end
  endtask

  task automatic test_async_reset();
    int w0 = wr_count;
    bit ok;
    send_magic();
    send_le32(32'd2);
    expect_write(0, 32'h04030201);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL arst_sysrst: got %b expected 1", sys_rst); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL arst_led: got %b expected 0", led); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL arst_we: got %b expected 0", ram_we); end
    checks++; if (ram_wdata !== '0) begin errors++; $display("FAIL arst_wdata: got %h expected 0", ram_wdata); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL arst_addr: got %h expected 0", ram_addr); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    send_magic();
    send_le32(32'd1);
    expect_write(0, 32'hCAFEF00D);
    send_le32(32'hCAFEF00D);
    wait_rst_high(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_release: system_reset_o still %b, expected 1", sys_rst); end
    checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL arst_writes: got %0d expected 2", wr_count - w0); end
    checks++; if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL arst_missing: %0d writes missing, expected 0", exp_addr_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err: got %b expected 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_noise_len0();
    test_len_overflow();
    test_timeout();
    test_framing_glitch();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
